// File: rtl/am2925_busctl.sv
// am2925_busctl: memory-port arbiter and microcycle stall sequencer for the am2925 clock generator.
// Shares one memory port between the CPU microengine and a DMA requester. It stalls the generator
// through waitreq_/ready_ and registers the cycle-length code onto the generator L inputs.
module am2925_busctl #(
  parameter int unsigned TMO   = 15,
  parameter int unsigned TMO_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c4,
  input  logic [2:0] len_code,
  input  logic       cpu_req,
  input  logic       dma_req,
  input  logic       mem_rdy,
  output logic [2:0] l,
  output logic       waitreq_,
  output logic       ready_,
  output logic       cpu_gnt,
  output logic       dma_gnt,
  output logic       mem_strb,
  output logic       bus_err
);

  localparam logic [2:0] L_F10 = 3'b100;
  localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TMO - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_ACC   = 2'd1,
    DMA_ACC   = 2'd2,
    CPU_STALL = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [TMO_W-1:0] cnt, cnt_nx;
  logic             c4_d;
  logic [2:0]       l_nx;
  logic             waitreq_nx, ready_nx, cpu_gnt_nx, dma_gnt_nx, mem_strb_nx, bus_err_nx;
  logic             bnd;

  // Microcycle boundary: rising edge of the generator c4 output.
  assign bnd = c4 & ~c4_d;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      c4_d     <= 1'b0;
      l        <= 3'b000;
      waitreq_ <= 1'b1;
      ready_   <= 1'b1;
      cpu_gnt  <= 1'b0;
      dma_gnt  <= 1'b0;
      mem_strb <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      c4_d     <= c4;
      l        <= l_nx;
      waitreq_ <= waitreq_nx;
      ready_   <= ready_nx;
      cpu_gnt  <= cpu_gnt_nx;
      dma_gnt  <= dma_gnt_nx;
      mem_strb <= mem_strb_nx;
      bus_err  <= bus_err_nx;
    end
  end

  // Next-state and next-output logic; the strobes default high so they pulse for a single clk.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    l_nx        = l;
    waitreq_nx  = 1'b1;
    ready_nx    = 1'b1;
    cpu_gnt_nx  = cpu_gnt;
    dma_gnt_nx  = dma_gnt;
    mem_strb_nx = mem_strb;
    bus_err_nx  = bus_err;

    // After a timeout, the generator is forced to the longest cycle.
    if (bnd) begin
      l_nx = bus_err ? L_F10 : len_code;
    end

    unique case (state)
      IDLE: begin
        if (bnd && cpu_req) begin
          state_nx    = CPU_ACC;
          cpu_gnt_nx  = 1'b1;
          mem_strb_nx = 1'b1;
          waitreq_nx  = 1'b0;
          cnt_nx      = '0;
        end else if (dma_req) begin
          state_nx   = DMA_ACC;
          dma_gnt_nx = 1'b1;
        end
      end

      CPU_ACC: begin
        cnt_nx = cnt + TMO_W'(1);
        // A completion that coincides with the timeout still counts as a success.
        if (mem_rdy || cnt == CNT_LAST) begin
          state_nx    = IDLE;
          ready_nx    = 1'b0;
          cpu_gnt_nx  = 1'b0;
          mem_strb_nx = 1'b0;
          if (!mem_rdy) begin
            bus_err_nx = 1'b1;
          end
        end
      end

      DMA_ACC: begin
        if (bnd && cpu_req && !dma_req) begin
          state_nx    = CPU_ACC;
          dma_gnt_nx  = 1'b0;
          cpu_gnt_nx  = 1'b1;
          mem_strb_nx = 1'b1;
          waitreq_nx  = 1'b0;
          cnt_nx      = '0;
        end else if (!dma_req) begin
          state_nx   = IDLE;
          dma_gnt_nx = 1'b0;
        end else if (bnd && cpu_req) begin
          state_nx   = CPU_STALL;
          waitreq_nx = 1'b0;
        end
      end

      CPU_STALL: begin
        // The generator stays held from the earlier waitreq_, so no second pulse is needed.
        if (!dma_req) begin
          state_nx    = CPU_ACC;
          dma_gnt_nx  = 1'b0;
          cpu_gnt_nx  = 1'b1;
          mem_strb_nx = 1'b1;
          cnt_nx      = '0;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_am2925_busctl.sv
// Testbench for am2925_busctl: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a behavioural ownership model.
module tb_am2925_busctl;

  localparam int unsigned TMO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       c4;
  logic [2:0] len_code;
  logic       cpu_req, dma_req, mem_rdy;
  logic [2:0] l;
  logic       waitreq_, ready_, cpu_gnt, dma_gnt, mem_strb, bus_err;

  int n_vec = 0;
  int n_bad = 0;

  am2925_busctl #(.TMO(TMO), .TMO_W(4)) dut (
    .clk(clk), .rst(rst), .c4(c4), .len_code(len_code), .cpu_req(cpu_req),
    .dma_req(dma_req), .mem_rdy(mem_rdy), .l(l), .waitreq_(waitreq_), .ready_(ready_),
    .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .mem_strb(mem_strb), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Packed observation: {l[2:0], waitreq_, ready_, cpu_gnt, dma_gnt, mem_strb, bus_err}
  function automatic logic [8:0] obs();
    return {l, waitreq_, ready_, cpu_gnt, dma_gnt, mem_strb, bus_err};
  endfunction

  localparam logic [8:0] RST_OBS = {3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got l=%b wq_=%b rd_=%b cg=%b dg=%b st=%b err=%b, required l=%b wq_=%b rd_=%b cg=%b dg=%b st=%b err=%b",
               name, got[8:6], got[5], got[4], got[3], got[2], got[1], got[0],
               exp[8:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one clk of inputs, then sample 1 time unit after the rising edge.
  task automatic apply(input logic i_c4, input logic [2:0] i_len, input logic i_cpu,
                       input logic i_dma, input logic i_rdy);
    c4 = i_c4; len_code = i_len; cpu_req = i_cpu; dma_req = i_dma; mem_rdy = i_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    c4 = 1'b0; len_code = 3'b000; cpu_req = 1'b0; dma_req = 1'b0; mem_rdy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- behavioural model: who owns memory, and since when ----------------
  localparam int OWN_NONE = 0;
  localparam int OWN_CPU  = 1;
  localparam int OWN_DMA  = 2;

  int         m_owner;
  bit         m_cpu_waiting;   // CPU asked while DMA held the port; generator is stalled
  int         m_age;           // clks the CPU access has been running
  bit         m_prev_c4;
  logic [2:0] m_l;
  bit         m_wq, m_rd, m_err;

  task automatic model_reset();
    m_owner = OWN_NONE; m_cpu_waiting = 0; m_age = 0; m_prev_c4 = 0;
    m_l = 3'b000; m_wq = 1; m_rd = 1; m_err = 0;
  endtask

  task automatic model_start_cpu();
    m_owner = OWN_CPU; m_age = 0; m_cpu_waiting = 0;
  endtask

  task automatic model_step(input bit i_c4, input logic [2:0] i_len, input bit i_cpu,
                            input bit i_dma, input bit i_rdy);
    bit boundary;
    bit err_before;
    boundary   = i_c4 && !m_prev_c4;
    m_prev_c4  = i_c4;
    err_before = m_err;
    m_wq = 1; m_rd = 1;
    if (boundary) m_l = err_before ? 3'b100 : i_len;
    if (m_owner == OWN_NONE) begin
      if (boundary && i_cpu) begin model_start_cpu(); m_wq = 0; end
      else if (i_dma) m_owner = OWN_DMA;
    end else if (m_owner == OWN_DMA) begin
      if (m_cpu_waiting) begin
        if (!i_dma) model_start_cpu();
      end else if (boundary && i_cpu) begin
        m_wq = 0;
        if (!i_dma) model_start_cpu();
        else m_cpu_waiting = 1;
      end else if (!i_dma) begin
        m_owner = OWN_NONE;
      end
    end else begin
      m_age++;
      if (i_rdy) begin
        m_rd = 0; m_owner = OWN_NONE;
      end else if (m_age == TMO) begin
        m_rd = 0; m_err = 1; m_owner = OWN_NONE;
      end
    end
  endtask

  function automatic logic [8:0] model_obs();
    return {m_l, m_wq, m_rd, m_owner == OWN_CPU, m_owner == OWN_DMA, m_owner == OWN_CPU, m_err};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic       c4;
    logic [2:0] len;
    logic       cpu;
    logic       dma;
    logic       rdy;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic i_c4, input logic [2:0] i_len, input logic i_cpu,
                              input logic i_dma, input logic i_rdy, input logic [8:0] e);
    vec_t v;
    v.c4 = i_c4; v.len = i_len; v.cpu = i_cpu; v.dma = i_dma; v.rdy = i_rdy; v.exp = e;
    return v;
  endfunction

  initial begin
    int first_low;
    bit c4_r, dma_r;

    // CPU access, DMA access, stall behind DMA, simultaneous requests, DMA drop at boundary.
    tbl[0]  = mk(0, 3'b101, 1, 0, 0, {3'b000, 6'b110000});
    tbl[1]  = mk(1, 3'b101, 1, 0, 0, {3'b101, 6'b011010});
    tbl[2]  = mk(1, 3'b101, 0, 0, 0, {3'b101, 6'b111010});
    tbl[3]  = mk(0, 3'b101, 0, 0, 0, {3'b101, 6'b111010});
    tbl[4]  = mk(0, 3'b101, 0, 0, 1, {3'b101, 6'b100000});
    tbl[5]  = mk(0, 3'b101, 0, 0, 0, {3'b101, 6'b110000});
    tbl[6]  = mk(0, 3'b101, 0, 1, 0, {3'b101, 6'b110100});
    tbl[7]  = mk(1, 3'b011, 1, 1, 0, {3'b011, 6'b010100});
    tbl[8]  = mk(1, 3'b011, 1, 1, 0, {3'b011, 6'b110100});
    tbl[9]  = mk(0, 3'b011, 0, 1, 0, {3'b011, 6'b110100});
    tbl[10] = mk(0, 3'b011, 0, 0, 0, {3'b011, 6'b111010});
    tbl[11] = mk(0, 3'b011, 0, 0, 1, {3'b011, 6'b100000});
    tbl[12] = mk(1, 3'b010, 1, 1, 0, {3'b010, 6'b011010});
    tbl[13] = mk(1, 3'b010, 0, 1, 1, {3'b010, 6'b100000});
    tbl[14] = mk(0, 3'b010, 0, 1, 0, {3'b010, 6'b110100});
    tbl[15] = mk(0, 3'b010, 0, 0, 0, {3'b010, 6'b110000});
    tbl[16] = mk(0, 3'b010, 0, 1, 0, {3'b010, 6'b110100});
    tbl[17] = mk(1, 3'b110, 1, 0, 0, {3'b110, 6'b011010});
    tbl[18] = mk(0, 3'b110, 0, 0, 1, {3'b110, 6'b100000});
    tbl[19] = mk(0, 3'b110, 0, 0, 1, {3'b110, 6'b110000});

    do_reset();
    check("reset_state", obs(), RST_OBS);
    foreach (tbl[i]) begin
      apply(tbl[i].c4, tbl[i].len, tbl[i].cpu, tbl[i].dma, tbl[i].rdy);
      check($sformatf("table_v%0d", i), obs(), tbl[i].exp);
    end

    // Completion exactly at the timeout clk counts as success.
    do_reset();
    apply(0, 3'b001, 0, 0, 0);
    apply(1, 3'b001, 1, 0, 0);
    check("tmo_edge_entry", obs(), {3'b001, 6'b011010});
    for (int k = 1; k < TMO; k++) apply(1, 3'b001, 0, 0, 0);
    check("tmo_edge_still_busy", obs(), {3'b001, 6'b111010});
    apply(1, 3'b001, 0, 0, 1);
    check("tmo_edge_success", obs(), {3'b001, 6'b100000});

    // Timeout: ready_ pulses TMO clks after entry and bus_err sticks.
    apply(0, 3'b001, 0, 0, 0);
    apply(1, 3'b001, 1, 0, 0);
    first_low = -1;
    for (int k = 1; k <= 3 * TMO; k++) begin
      apply(1, 3'b000, 0, 0, 0);
      if (ready_ == 1'b0) begin first_low = k; break; end
    end
    n_vec++;
    if (first_low != int'(TMO)) begin
      n_bad++;
      $display("FAIL tmo_latency: ready_ low after %0d clks, required %0d", first_low, TMO);
    end
    check("tmo_outputs", obs(), {3'b001, 6'b100001});
    apply(0, 3'b000, 0, 0, 0);
    apply(1, 3'b000, 0, 0, 0);
    check("tmo_forces_f10", obs(), {3'b100, 6'b110001});

    // Reset in the middle of a CPU access: immediate return to reset values, no ready_.
    do_reset();
    apply(0, 3'b111, 0, 0, 0);
    apply(1, 3'b111, 1, 0, 0);
    apply(1, 3'b111, 0, 0, 0);
    check("rst_mid_pre", obs(), {3'b111, 6'b111010});
    #2 rst = 1'b1;
    #1 check("rst_mid_async", obs(), RST_OBS);
    mem_rdy = 1'b1;
    @(posedge clk);
    #1 check("rst_mid_held", obs(), RST_OBS);
    rst = 1'b0;
    apply(0, 3'b111, 0, 0, 0);
    check("rst_mid_after", obs(), RST_OBS);

    // Randomized traffic against the ownership model.
    c4_r = 0; dma_r = 0;
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      model_reset();
      check($sformatf("rand_reset_%0d", blk), obs(), model_obs());
      c4_r = 0; dma_r = 0;
      for (int n = 0; n < 400; n++) begin
        logic [2:0] r_len;
        bit r_cpu, r_rdy;
        if ($urandom_range(0, 2) == 0) c4_r = ~c4_r;
        if ($urandom_range(0, 7) == 0) dma_r = ~dma_r;
        r_len = 3'($urandom_range(0, 7));
        r_cpu = ($urandom_range(0, 1) == 1);
        r_rdy = (blk == 5) ? 1'b0 : ($urandom_range(0, 9) == 0);
        apply(c4_r, r_len, r_cpu, dma_r, r_rdy);
        model_step(c4_r, r_len, r_cpu, dma_r, r_rdy);
        check($sformatf("rand_b%0d_c%0d", blk, n), obs(), model_obs());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
